line_raster_writer: RTL

Bresenham line rasterizer that sits directly upstream of the VGA frame-buffer system. It accepts line commands (two endpoints plus an RGB444 color) from the 3D engine's geometry stage. Each pixel is written into the SDRAM frame buffer through an Avalon-MM write master, which the VGA pixel-buffer DMA then scans out. Off-screen pixels are clipped, one line is rasterized at a time, and there is no command queue.

---
 rtl/raster_pkg.sv | 21 ++
 rtl/fb_addr_gen.sv | 50 +++++
 rtl/line_raster_writer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared types and constants for the line rasterizer: FSM states and the
// RGB444-to-frame-buffer pixel word packing.
package raster_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ADDR,
        ST_WRITE,
        ST_STEP
    } state_t;

    localparam logic [1:0] PIXEL_BYTEENABLE = 2'b11;
    localparam logic [3:0] PIXEL_PAD        = 4'h0;

    // Frame-buffer pixel word is {4'h0, R, G, B}.
    function automatic logic [15:0] pack_rgb444(input logic [11:0] color);
        return {PIXEL_PAD, color};
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Frame-buffer address generator: registers FB_BASE + ((y*H_RES + x) << 1)
// on load and flags whether (x, y) lies on screen.
module fb_addr_gen
    import raster_pkg::*;
#(
    parameter int                 H_RES   = 320,
    parameter int                 V_RES   = 240,
    parameter int                 X_W     = 10,
    parameter int                 Y_W     = 9,
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  FB_BASE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              on_screen
);

    localparam int XL = X_W + 1;
    localparam int YL = Y_W + 1;
    // One extra bit so a resolution equal to 2**X_W still compares correctly.
    localparam logic [X_W:0] H_LIM = XL'(H_RES);
    localparam logic [Y_W:0] V_LIM = YL'(V_RES);

    logic [ADDR_W-1:0] pixel_index;
    logic [ADDR_W-1:0] addr_d, addr_q;

    always_comb begin
        on_screen   = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
        pixel_index = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
        addr_d      = addr_q;
        if (load) begin
            addr_d = FB_BASE + (pixel_index << 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/line_raster_writer.sv
// Bresenham line rasterizer writing RGB444 pixels into an SDRAM frame buffer
// through an Avalon-MM write master, clipping pixels that fall off screen.
module line_raster_writer
    import raster_pkg::*;
#(
    parameter int                 H_RES   = 320,
    parameter int                 V_RES   = 240,
    parameter int                 X_W     = 10,
    parameter int                 Y_W     = 9,
    parameter int                 ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]  FB_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [X_W-1:0]    cmd_x0,
    input  logic [X_W-1:0]    cmd_x1,
    input  logic [Y_W-1:0]    cmd_y0,
    input  logic [Y_W-1:0]    cmd_y1,
    input  logic [11:0]       cmd_color,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [15:0]       avm_writedata,
    output logic [1:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done
);

    // Error term width: room for 2*err over the full coordinate range.
    localparam int EW = ((X_W > Y_W) ? X_W : Y_W) + 2;

    state_t state_q, state_d;

    logic [X_W-1:0]       x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
    logic [Y_W-1:0]       y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d;
    logic [15:0]          data_q, data_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                 done_q, done_d;

    logic signed [EW-1:0] e2;
    logic [X_W-1:0]       adx;
    logic [Y_W-1:0]       ady;
    logic                 at_end;
    logic                 on_screen;
    logic                 addr_load;

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        data_d    = data_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        sx_neg_d  = sx_neg_q;
        sy_neg_d  = sy_neg_q;
        done_d    = 1'b0;
        addr_load = 1'b0;

        adx    = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady    = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        e2     = err_q <<< 1;
        at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    x1_d    = cmd_x1;
                    y0_d    = cmd_y0;
                    y1_d    = cmd_y1;
                    data_d  = pack_rgb444(cmd_color);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dx_d     = signed'(EW'(adx));
                dy_d     = -signed'(EW'(ady));
                err_d    = signed'(EW'(adx)) - signed'(EW'(ady));
                sx_neg_d = (x1_q < x0_q);
                sy_neg_d = (y1_q < y0_q);
                cur_x_d  = x0_q;
                cur_y_d  = y0_q;
                state_d  = ST_ADDR;
            end
            ST_ADDR: begin
                addr_load = on_screen;
                state_d   = on_screen ? ST_WRITE : ST_STEP;
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (at_end) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Both tests use the pre-step err; both moves may apply.
                    if (e2 >= dy_q) begin
                        err_d   = err_d + dy_q;
                        cur_x_d = sx_neg_q ? (cur_x_q - X_W'(1)) : (cur_x_q + X_W'(1));
                    end
                    if (e2 <= dx_q) begin
                        err_d   = err_d + dx_q;
                        cur_y_d = sy_neg_q ? (cur_y_q - Y_W'(1)) : (cur_y_q + Y_W'(1));
                    end
                    state_d = ST_ADDR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            data_q   <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            x1_q     <= x1_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            data_q   <= data_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            done_q   <= done_d;
        end
    end

    fb_addr_gen #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .ADDR_W  (ADDR_W),
        .FB_BASE (FB_BASE)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (addr_load),
        .x         (cur_x_q),
        .y         (cur_y_q),
        .addr      (avm_address),
        .on_screen (on_screen)
    );

    // Decoded straight from state so an async reset drops the write at once.
    assign cmd_ready      = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign avm_write      = (state_q == ST_WRITE);
    assign avm_writedata  = data_q;
    assign avm_byteenable = PIXEL_BYTEENABLE;
    assign done           = done_q;

endmodule
